// File: rtl/game_pkg.sv
// Shared constants and FSM state encoding for the 2048 board datapath.
package game_pkg;

    localparam int BOARD_CELLS     = 16;
    localparam int EXP_W           = 4;
    localparam int ADDR_W          = 4;
    localparam int DEFAULT_MAX_EXP = 14;
    localparam int DEFAULT_WIN_EXP = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/tile_value_decoder.sv
// Registered exponent-to-tile-value decoder; the exponent and valid bit ride alongside the value.
module tile_value_decoder
    import game_pkg::*;
#(
    parameter int SUM_W   = 20,
    parameter int MAX_EXP = DEFAULT_MAX_EXP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    output logic [EXP_W-1:0] out_exp,
    output logic [SUM_W-1:0] out_value
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_exp   <= '0;
            out_value <= '0;
        end else begin
            out_valid <= in_valid;
            out_exp   <= in_exp;
            // Empty cells and exponents beyond the tile range carry no value.
            if (in_exp == '0 || in_exp > EXP_W'(MAX_EXP)) begin
                out_value <= '0;
            end else begin
                out_value <= SUM_W'(1) << in_exp;
            end
        end
    end

endmodule

// File: rtl/score_scan_controller.sv
// Sweeps the 16 board cells once per request and publishes sum, max exponent,
// empty count and win flag with a one-cycle done pulse.
module score_scan_controller
    import game_pkg::*;
#(
    parameter int SUM_W   = 20,
    parameter int MAX_EXP = DEFAULT_MAX_EXP,
    parameter int WIN_EXP = DEFAULT_WIN_EXP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cell_addr,
    input  logic [EXP_W-1:0]  cell_exp,
    output logic [SUM_W-1:0]  score_sum,
    output logic [EXP_W-1:0]  max_exp,
    output logic [4:0]        empty_cnt,
    output logic              win
);

    scan_state_t      state;
    logic             addr_valid;
    logic             rd_valid;
    logic             drain_cnt;

    logic             dec_valid;
    logic [EXP_W-1:0] dec_exp;
    logic [SUM_W-1:0] dec_value;

    logic [SUM_W-1:0] acc_sum,   sum_nx;
    logic [EXP_W-1:0] acc_max,   max_nx;
    logic [4:0]       acc_empty, empty_nx;
    logic             acc_win,   win_nx;

    tile_value_decoder #(
        .SUM_W   (SUM_W),
        .MAX_EXP (MAX_EXP)
    ) u_decoder (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_valid),
        .in_exp    (cell_exp),
        .out_valid (dec_valid),
        .out_exp   (dec_exp),
        .out_value (dec_value)
    );

    // Next accumulator values; publishing uses these so the last cell lands in the result.
    always_comb begin
        sum_nx   = acc_sum;
        max_nx   = acc_max;
        empty_nx = acc_empty;
        win_nx   = acc_win;
        if (dec_valid) begin
            sum_nx = acc_sum + dec_value;
            if (dec_exp != '0 && dec_exp <= EXP_W'(MAX_EXP) && dec_exp > acc_max) begin
                max_nx = dec_exp;
            end
            if (dec_exp == '0) begin
                empty_nx = acc_empty + 5'd1;
            end
            if (dec_exp == EXP_W'(WIN_EXP)) begin
                win_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            cell_addr  <= '0;
            addr_valid <= 1'b0;
            rd_valid   <= 1'b0;
            drain_cnt  <= 1'b0;
            acc_sum    <= '0;
            acc_max    <= '0;
            acc_empty  <= '0;
            acc_win    <= 1'b0;
            score_sum  <= '0;
            max_exp    <= '0;
            empty_cnt  <= '0;
            win        <= 1'b0;
        end else begin
            done      <= 1'b0;
            rd_valid  <= addr_valid;
            acc_sum   <= sum_nx;
            acc_max   <= max_nx;
            acc_empty <= empty_nx;
            acc_win   <= win_nx;
            busy      <= (state == SCAN) || (state == DRAIN);
            case (state)
                // The done cycle also accepts start so a held request runs back-to-back.
                IDLE, DONE: begin
                    if (start) begin
                        state      <= SCAN;
                        cell_addr  <= '0;
                        addr_valid <= 1'b1;
                        acc_sum    <= '0;
                        acc_max    <= '0;
                        acc_empty  <= '0;
                        acc_win    <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    if (cell_addr == ADDR_W'(BOARD_CELLS - 1)) begin
                        state      <= DRAIN;
                        addr_valid <= 1'b0;
                        drain_cnt  <= 1'b0;
                    end else begin
                        cell_addr <= cell_addr + 4'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        score_sum <= sum_nx;
                        max_exp   <= max_nx;
                        empty_cnt <= empty_nx;
                        win       <= win_nx;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_scan_controller.sv
// Self-checking bench: directed and random boards compared against a board-level reference model.
module tb_score_scan_controller;
    import game_pkg::*;

    localparam int SUM_W   = 20;
    localparam int MAX_E   = 14;
    localparam int WIN_E   = 11;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             busy;
    logic             done;
    logic [3:0]       cell_addr;
    logic [3:0]       cell_exp = 4'd0;
    logic [SUM_W-1:0] score_sum;
    logic [3:0]       max_exp;
    logic [4:0]       empty_cnt;
    logic             win;

    logic [3:0] board [16];

    int num_checks = 0;
    int num_errors = 0;
    int exp_sum, exp_max, exp_empty, exp_win;
    int prev_sum = 0;

    score_scan_controller #(
        .SUM_W   (SUM_W),
        .MAX_EXP (MAX_E),
        .WIN_EXP (WIN_E)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .cell_addr (cell_addr),
        .cell_exp  (cell_exp),
        .score_sum (score_sum),
        .max_exp   (max_exp),
        .empty_cnt (empty_cnt),
        .win       (win)
    );

    always #5 clk = ~clk;

    // Board store with a one-cycle registered read
    always @(posedge clk) cell_exp <= board[cell_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: summary computed straight from the board contents
    task automatic compute_expected();
        exp_sum = 0; exp_max = 0; exp_empty = 0; exp_win = 0;
        for (int i = 0; i < 16; i++) begin
            int e;
            e = int'(board[i]);
            if (e == 0) exp_empty++;
            else if (e <= MAX_E) begin
                exp_sum += 2 ** e;
                if (e > exp_max) exp_max = e;
            end
            if (e == WIN_E) exp_win = 1;
        end
    endtask

    task automatic check_results(input string name);
        check_output({name, " score_sum"}, 32'(score_sum), exp_sum);
        check_output({name, " max_exp"}, 32'(max_exp), exp_max);
        check_output({name, " empty_cnt"}, 32'(empty_cnt), exp_empty);
        check_output({name, " win"}, 32'(win), exp_win);
    endtask

    task automatic check_all_zero(input string name);
        check_output({name, " busy"}, 32'(busy), 0);
        check_output({name, " done"}, 32'(done), 0);
        check_output({name, " cell_addr"}, 32'(cell_addr), 0);
        check_output({name, " score_sum"}, 32'(score_sum), 0);
        check_output({name, " max_exp"}, 32'(max_exp), 0);
        check_output({name, " empty_cnt"}, 32'(empty_cnt), 0);
        check_output({name, " win"}, 32'(win), 0);
    endtask

    // One scan from idle; poke_at re-pulses start mid-scan, reset_at aborts the scan
    task automatic apply_stimulus(input string name, input int poke_at, input int reset_at);
        int done_at;
        int busy_cycles;
        int extra_dones;
        done_at = -1;
        busy_cycles = 0;
        compute_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) tick();
            if (k == reset_at) begin
                rst = 1'b0;
                tick();
                check_all_zero({name, " abort"});
                rst = 1'b1;
                extra_dones = 0;
                for (int j = 0; j < 25; j++) begin
                    tick();
                    if (done) extra_dones++;
                end
                check_output({name, " no done after abort"}, extra_dones, 0);
                prev_sum = 0;
                return;
            end
            if (busy) busy_cycles++;
            if (k <= 15) check_output({name, " cell_addr"}, 32'(cell_addr), k);
            if (k == 17) check_output({name, " held score_sum"}, 32'(score_sum), prev_sum);
            start = (k == poke_at) ? 1'b1 : 1'b0;
            if (done) begin
                done_at = k;
                break;
            end
        end
        start = 1'b0;
        check_output({name, " latency"}, done_at, 18);
        check_results(name);
        check_output({name, " busy cycles"}, busy_cycles, 18);
        tick();
        check_output({name, " done pulse width"}, 32'(done), 0);
        check_output({name, " busy after done"}, 32'(busy), 0);
        extra_dones = 0;
        for (int j = 0; j < 22; j++) begin
            tick();
            if (done) extra_dones++;
        end
        check_output({name, " extra dones"}, extra_dones, 0);
        check_results({name, " stable"});
        prev_sum = exp_sum;
    endtask

    task automatic fill_board(input int value);
        for (int i = 0; i < 16; i++) board[i] = 4'(value);
    endtask

    initial begin
        int dones;
        int last_done;

        fill_board(0);
        rst = 1'b0;
        tick(); tick(); tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        fill_board(0);
        apply_stimulus("empty board", -1, -1);

        fill_board(0);
        board[0] = 4'd1; board[1] = 4'd2; board[2] = 4'd3; board[3] = 4'd11;
        apply_stimulus("win board", -1, -1);

        fill_board(14);
        apply_stimulus("full 14", -1, -1);

        board[5] = 4'd15;
        apply_stimulus("cell5 15", -1, -1);

        for (int i = 0; i < 16; i++) board[i] = 4'($urandom_range(0, 15));
        apply_stimulus("restart ignored", 5, -1);

        for (int i = 0; i < 16; i++) board[i] = 4'($urandom_range(0, 15));
        apply_stimulus("mid reset", -1, 10);
        apply_stimulus("after reset", -1, -1);

        // Held start: back-to-back scans on a fixed board
        for (int i = 0; i < 16; i++) board[i] = 4'($urandom_range(0, 12));
        compute_expected();
        dones = 0;
        last_done = -1;
        start = 1'b1;
        tick();
        for (int k = 1; k < 60; k++) begin
            tick();
            if (done) begin
                dones++;
                if (last_done >= 0) check_output("b2b spacing", k - last_done, 19);
                else check_output("b2b first latency", k, 18);
                last_done = k;
                check_results("b2b");
            end
        end
        start = 1'b0;
        check_output("b2b done count", dones, 3);
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        prev_sum = 0;

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 3) == 0) board[i] = 4'd0;
                else board[i] = 4'($urandom_range(1, 15));
            end
            apply_stimulus($sformatf("random %0d", n), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
